// File: rtl/block_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the block-serial subtractor.
// Block partition matches the combinational CLA adder library.
package block_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int WIDTH_DEF = 14;
    localparam int BLK_DEF   = 4;

    function automatic int num_blk(input int w, input int b);
        return (w + b - 1) / b;
    endfunction

    function automatic int last_blk(input int w, input int b);
        return w - (num_blk(w, b) - 1) * b;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_BLK   = num_blk(WIDTH_DEF, BLK_DEF);
    localparam int LAST_BLK  = last_blk(WIDTH_DEF, BLK_DEF);
    localparam int BLK_IDX_W = idx_w(NUM_BLK);

endpackage

// File: rtl/block_serial_subtractor_cla.sv
// Combinational carry-look-ahead block; the final partial block
// masks its padded bits and takes its carry at bit LAST_W-1.
module cla_block_unit
    import block_serial_subtractor_pkg::*;
#(
    parameter int BLK    = BLK_DEF,
    parameter int LAST_W = LAST_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    input  logic           last,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           grp_g,
    output logic           grp_p
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   gg;
    logic [BLK:0]   gp;
    logic [BLK-1:0] c;

    always_comb begin
        g  = '0;
        p  = '0;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int i = 0; i < BLK; i++) begin
            if (!last || (i < LAST_W)) begin
                g[i] = a[i] & b[i];
                p[i] = a[i] ^ b[i];
            end
        end
        gp[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            gg[i+1] = g[i] | (p[i] & gg[i]);
            gp[i+1] = p[i] & gp[i];
        end
        for (int i = 0; i < BLK; i++) begin
            c[i] = gg[i] | (gp[i] & cin);
        end
        sum   = p ^ c;
        grp_g = last ? gg[LAST_W] : gg[BLK];
        grp_p = last ? gp[LAST_W] : gp[BLK];
        cout  = grp_g | (grp_p & cin);
    end

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial unsigned subtractor: diff = x + ~y + 1, one CLA
// block per cycle with the inter-block carry held in a flop.
module block_serial_subtractor
    import block_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLK   = BLK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NB = num_blk(WIDTH, BLK);
    localparam int LW = last_blk(WIDTH, BLK);
    localparam int IW = idx_w(NB);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    blk_idx_q, blk_idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BLK-1:0]   a_blk;
    logic [BLK-1:0]   b_blk;
    logic [BLK-1:0]   sum_w;
    logic             cout_w;
    logic             grp_g_w;
    logic             grp_p_w;
    logic             last_w;

    assign last_w = (blk_idx_q == IW'(NB - 1));

    always_comb begin
        a_blk = '0;
        b_blk = '0;
        for (int j = 0; j < BLK; j++) begin : sel
            int pos;
            pos = int'(blk_idx_q) * BLK + j;
            if (pos < WIDTH) begin
                a_blk[j] = a_q[AW'(pos)];
                b_blk[j] = b_q[AW'(pos)];
            end
        end
    end

    cla_block_unit #(
        .BLK    (BLK),
        .LAST_W (LW)
    ) u_cla (
        .a     (a_blk),
        .b     (b_blk),
        .cin   (carry_q),
        .last  (last_w),
        .sum   (sum_w),
        .cout  (cout_w),
        .grp_g (grp_g_w),
        .grp_p (grp_p_w)
    );

    // Block carry-out must agree with the group generate/propagate terms.
    assert property (@(posedge clk) disable iff (!rst_n)
        cout_w == (grp_g_w | (grp_p_w & carry_q)));

    always_comb begin
        state_d     = state_q;
        blk_idx_d   = blk_idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = x;
                    b_d        = ~y;
                    carry_d    = 1'b1;
                    blk_idx_d  = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (IW'(k / BLK) == blk_idx_q) begin
                        diff_d[k] = sum_w[k % BLK];
                    end
                end
                carry_d   = cout_w;
                blk_idx_d = blk_idx_q + IW'(1);
                if (last_w) begin
                    borrow_d    = ~cout_w;
                    blk_idx_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            blk_idx_q   <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_idx_q   <= blk_idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Directed bench for block_serial_subtractor with hand-computed
// expected results, latency, backpressure and mid-op reset.
module tb_block_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] x;
    logic [13:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] diff;
    logic        borrow;

    int n_tests = 0;
    int n_fail  = 0;

    block_serial_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [13:0] xv,
                        input logic [13:0] yv);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 1);
        x        = xv;
        y        = yv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = ~xv;
        y        = xv ^ yv;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 4);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ovl"}, 32'(out_valid), 0);
        check({tag, "_irdy"}, 32'(in_ready), 1);
    endtask

    task automatic run(input string tag, input logic [13:0] xv,
                       input logic [13:0] yv, input logic [13:0] ed,
                       input logic eb);
        send(tag, xv, yv);
        check({tag, "_busy"}, 32'(in_ready), 0);
        wait_done(tag);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_brw"}, 32'(borrow), 32'(eb));
        take(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        #12;
        check("rst_irdy", 32'(in_ready), 1);
        check("rst_ovl", 32'(out_valid), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_brw", 32'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("basic", 14'd5000, 14'd1234, 14'd3766, 1'b0);
        run("under", 14'd0, 14'd1, 14'd16383, 1'b1);
        run("equal", 14'd16383, 14'd16383, 14'd0, 1'b0);
        run("rip12", 14'd4096, 14'd1, 14'd4095, 1'b0);
        run("rip13", 14'h2000, 14'h0001, 14'h1FFF, 1'b0);
        run("neg", 14'd1234, 14'd5000, 14'd12618, 1'b1);
        run("maxz", 14'h3FFF, 14'd0, 14'h3FFF, 1'b0);

        // Backpressure: DONE must hold steady while out_ready is low.
        out_ready = 1'b0;
        send("bp", 14'd100, 14'd200);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_ovl", 32'(out_valid), 1);
            check("bp_diff", 32'(diff), 16284);
            check("bp_brw", 32'(borrow), 1);
            check("bp_irdy", 32'(in_ready), 0);
        end
        take("bp");

        // Request held across BUSY/DONE with changed operands.
        @(negedge clk);
        x        = 14'd300;
        y        = 14'd45;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x = 14'd7000;
        y = 14'd6999;
        wait_done("hold1");
        check("hold1_diff", 32'(diff), 255);
        check("hold1_brw", 32'(borrow), 0);
        @(posedge clk);
        #1;
        check("hold1_ovl", 32'(out_valid), 0);
        check("hold1_irdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        check("hold2_acc", 32'(in_ready), 0);
        in_valid = 1'b0;
        wait_done("hold2");
        check("hold2_diff", 32'(diff), 1);
        check("hold2_brw", 32'(borrow), 0);
        take("hold2");

        // Asynchronous reset while block 2 is pending.
        send("abort", 14'd9000, 14'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ovl", 32'(out_valid), 0);
        check("abort_diff", 32'(diff), 0);
        check("abort_brw", 32'(borrow), 0);
        check("abort_irdy", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run("post", 14'd10, 14'd3, 14'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
